// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// single-entry output holding register with parity, framing, break and overrun status.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_input,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detected,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync_p0, sync_p1;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, any_one, stop_bad, frame_done;
  logic                 line, bit_tick, stop_bad_now, is_break;

  function automatic logic parity_check(input logic acc);
    case (PARITY)
      1:       return acc;
      2:       return ~acc;
      default: return 1'b0;
    endcase
  endfunction

  assign line         = sync_p1;
  assign bit_tick     = (cnt == CNT_LAST);
  assign stop_bad_now = stop_bad | ~line;
  assign is_break     = ~any_one & stop_bad;

  // Stage p0/p1: metastability guard on the asynchronous line
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uart_input;
      sync_p1 <= sync_p0;
    end
  end

  // Frame FSM: accumulators are cleared on start so the held results stay readable for delivery
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      stop_bad   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!line) begin
            state    <= S_START;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            any_one  <= 1'b0;
            stop_bad <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= line ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shreg   <= {line, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ line;
            any_one <= any_one | line;
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == BIT_LAST) state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_acc <= par_acc ^ line;
            any_one <= any_one | line;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt      <= '0;
            stop_bad <= stop_bad_now;
            stop_idx <= ~stop_idx;
            if (stop_idx == STOP_LAST) begin
              frame_done <= 1'b1;
              state      <= stop_bad_now ? S_WAIT_HIGH : S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (line) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p2: delivery into the holding register; a full, stalled register drops the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      break_detected <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      break_detected <= 1'b0;
      overrun        <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (frame_done) begin
        if (is_break) begin
          break_detected <= 1'b1;
        end else if (!out_valid || out_ready) begin
          out_data      <= shreg;
          parity_error  <= parity_check(par_acc);
          framing_error <= stop_bad;
          out_valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
